// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer:
// state encoding, opcode values and the execute-class vector.
package cpu_ctrl_pkg;

   localparam int OPC_W           = 5;
   localparam int OPC_MSB_DEFAULT = 31;
   localparam int OPC_LSB_DEFAULT = OPC_MSB_DEFAULT - OPC_W + 1;

   localparam logic [OPC_W-1:0] OP_MFHI = 5'b11000;
   localparam logic [OPC_W-1:0] OP_MFLO = 5'b11001;
   localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
   localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
   localparam logic [OPC_W-1:0] OP_JR   = 5'b10100;
   localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_RESET   = 4'd0,
      ST_T0      = 4'd1,
      ST_T1      = 4'd2,
      ST_T1W     = 4'd3,
      ST_T2      = 4'd4,
      ST_T3      = 4'd5,
      ST_STOPPED = 4'd6,
      ST_HALTED  = 4'd7
   } ctrl_state_e;

   // One-hot execute class; exactly one bit set for a legal opcode.
   typedef struct packed {
      logic mfhi;
      logic mflo;
      logic inp;
      logic outp;
      logic jr;
      logic nop;
      logic halt;
   } exec_class_t;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode classifier: maps the 5-bit opcode to a one-hot
// execute class plus an illegal flag for anything unsupported.
module ctrl_opcode_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [OPC_W-1:0] opcode_i,
   output exec_class_t      class_o,
   output logic             illegal_o
);

   // Opcode to class lookup; unknown opcodes raise illegal only.
   always_comb begin
      class_o   = '0;
      illegal_o = 1'b0;
      case (opcode_i)
         OP_MFHI: class_o.mfhi = 1'b1;
         OP_MFLO: class_o.mflo = 1'b1;
         OP_IN:   class_o.inp  = 1'b1;
         OP_OUT:  class_o.outp = 1'b1;
         OP_JR:   class_o.jr   = 1'b1;
         OP_NOP:  class_o.nop  = 1'b1;
         OP_HALT: class_o.halt = 1'b1;
         default: illegal_o    = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Hardwired fetch/execute sequencer for the multi-cycle datapath. Strobes
// are decoded from the state register so Clear removes them immediately.
module mc_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 0,
   parameter int unsigned OPC_MSB  = 31
) (
   input  logic        Clock,
   input  logic        Clear,
   input  logic [31:0] IR,
   input  logic        Stop,
   output logic        Run,
   output logic        Illegal,
   output logic        PCout,
   output logic        MAR_enable,
   output logic        IncPC,
   output logic        ZLowIn,
   output logic        ZLowout,
   output logic        PC_enable,
   output logic        MDR_read,
   output logic        MDR_enable,
   output logic        MDRout,
   output logic        IR_enable,
   output logic        Gra,
   output logic        R_in,
   output logic        R_out,
   output logic        HIout,
   output logic        LOout,
   output logic        InPortout,
   output logic        OutPort_enable
);

   localparam logic [2:0] WAIT_LOAD = 3'((MEM_WAIT > 32'd0) ? (MEM_WAIT - 32'd1) : 32'd0);

   ctrl_state_e       state_q, state_d;
   logic [2:0]        wait_q, wait_d;
   logic [OPC_W-1:0]  opcode_s;
   exec_class_t       class_s;
   logic              illegal_s;
   logic              unused_bits;

   assign opcode_s    = IR[OPC_MSB -: OPC_W];
   assign unused_bits = ^{IR, class_s.nop};

   ctrl_opcode_decode u_decode (
      .opcode_i  (opcode_s),
      .class_o   (class_s),
      .illegal_o (illegal_s)
   );

   // Next-state and wait-counter logic; Stop is only looked at on leaving T3.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         ST_RESET: state_d = ST_T0;
         ST_T0:    state_d = ST_T1;
         ST_T1: begin
            if (MEM_WAIT == 32'd0) begin
               state_d = ST_T2;
            end else begin
               wait_d  = WAIT_LOAD;
               state_d = ST_T1W;
            end
         end
         ST_T1W: begin
            if (wait_q == 3'd0) begin
               state_d = ST_T2;
            end else begin
               wait_d = wait_q - 3'd1;
            end
         end
         ST_T2: state_d = ST_T3;
         ST_T3: begin
            if (class_s.halt) begin
               state_d = ST_HALTED;
            end else if (Stop) begin
               state_d = ST_STOPPED;
            end else begin
               state_d = ST_T0;
            end
         end
         ST_STOPPED: begin
            if (!Stop) begin
               state_d = ST_T0;
            end else begin
               state_d = ST_STOPPED;
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RESET;
      endcase
   end

   // State and counter registers with asynchronous Clear.
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state_q <= ST_RESET;
         wait_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Strobe decode; IR only influences outputs while in T3.
   always_comb begin
      Run            = 1'b1;
      Illegal        = 1'b0;
      PCout          = 1'b0;
      MAR_enable     = 1'b0;
      IncPC          = 1'b0;
      ZLowIn         = 1'b0;
      ZLowout        = 1'b0;
      PC_enable      = 1'b0;
      MDR_read       = 1'b0;
      MDR_enable     = 1'b0;
      MDRout         = 1'b0;
      IR_enable      = 1'b0;
      Gra            = 1'b0;
      R_in           = 1'b0;
      R_out          = 1'b0;
      HIout          = 1'b0;
      LOout          = 1'b0;
      InPortout      = 1'b0;
      OutPort_enable = 1'b0;
      case (state_q)
         ST_T0: begin
            PCout      = 1'b1;
            MAR_enable = 1'b1;
            IncPC      = 1'b1;
            ZLowIn     = 1'b1;
         end
         ST_T1: begin
            ZLowout    = 1'b1;
            PC_enable  = 1'b1;
            MDR_read   = 1'b1;
            MDR_enable = 1'b1;
         end
         ST_T1W: begin
            MDR_read   = 1'b1;
            MDR_enable = 1'b1;
         end
         ST_T2: begin
            MDRout    = 1'b1;
            IR_enable = 1'b1;
         end
         ST_T3: begin
            Gra            = class_s.mfhi | class_s.mflo | class_s.inp | class_s.outp | class_s.jr;
            R_in           = class_s.mfhi | class_s.mflo | class_s.inp;
            R_out          = class_s.outp | class_s.jr;
            HIout          = class_s.mfhi;
            LOout          = class_s.mflo;
            InPortout      = class_s.inp;
            OutPort_enable = class_s.outp;
            PC_enable      = class_s.jr;
            Illegal        = illegal_s;
         end
         default: Run = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: expected per-cycle strobe vectors are
// queued as each instruction is issued and compared on every falling edge.
module tb_mc_control_unit;

   localparam int B_RUN = 18, B_ILL = 17, B_PCOUT = 16, B_MAR = 15, B_INCPC = 14;
   localparam int B_ZLIN = 13, B_ZLOUT = 12, B_PCEN = 11, B_MDRRD = 10, B_MDREN = 9;
   localparam int B_MDROUT = 8, B_IREN = 7, B_GRA = 6, B_RIN = 5, B_ROUT = 4;
   localparam int B_HI = 3, B_LO = 2, B_INP = 1, B_OUTEN = 0;

   typedef enum int {P_IDLE, P_T0, P_T1, P_T1W, P_T2, P_T3} phase_e;

   logic        clk = 1'b0;
   logic        clr_a, clr_b, stop_a, stop_b;
   logic [31:0] ir_a, ir_b;
   wire  [18:0] vec_a, vec_b;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [18:0] exp_q[$];

   always #5 clk = ~clk;

   mc_control_unit #(.MEM_WAIT(0)) dut_w0 (
      .Clock(clk), .Clear(clr_a), .IR(ir_a), .Stop(stop_a),
      .Run(vec_a[B_RUN]), .Illegal(vec_a[B_ILL]), .PCout(vec_a[B_PCOUT]),
      .MAR_enable(vec_a[B_MAR]), .IncPC(vec_a[B_INCPC]), .ZLowIn(vec_a[B_ZLIN]),
      .ZLowout(vec_a[B_ZLOUT]), .PC_enable(vec_a[B_PCEN]), .MDR_read(vec_a[B_MDRRD]),
      .MDR_enable(vec_a[B_MDREN]), .MDRout(vec_a[B_MDROUT]), .IR_enable(vec_a[B_IREN]),
      .Gra(vec_a[B_GRA]), .R_in(vec_a[B_RIN]), .R_out(vec_a[B_ROUT]), .HIout(vec_a[B_HI]),
      .LOout(vec_a[B_LO]), .InPortout(vec_a[B_INP]), .OutPort_enable(vec_a[B_OUTEN])
   );

   mc_control_unit #(.MEM_WAIT(2)) dut_w2 (
      .Clock(clk), .Clear(clr_b), .IR(ir_b), .Stop(stop_b),
      .Run(vec_b[B_RUN]), .Illegal(vec_b[B_ILL]), .PCout(vec_b[B_PCOUT]),
      .MAR_enable(vec_b[B_MAR]), .IncPC(vec_b[B_INCPC]), .ZLowIn(vec_b[B_ZLIN]),
      .ZLowout(vec_b[B_ZLOUT]), .PC_enable(vec_b[B_PCEN]), .MDR_read(vec_b[B_MDRRD]),
      .MDR_enable(vec_b[B_MDREN]), .MDRout(vec_b[B_MDROUT]), .IR_enable(vec_b[B_IREN]),
      .Gra(vec_b[B_GRA]), .R_in(vec_b[B_RIN]), .R_out(vec_b[B_ROUT]), .HIout(vec_b[B_HI]),
      .LOout(vec_b[B_LO]), .InPortout(vec_b[B_INP]), .OutPort_enable(vec_b[B_OUTEN])
   );

   function automatic logic [18:0] exp_vec(phase_e p, logic [4:0] opc);
      logic [18:0] v;
      v = 19'd0;
      case (p)
         P_T0: begin
            v[B_RUN] = 1'b1; v[B_PCOUT] = 1'b1; v[B_MAR] = 1'b1;
            v[B_INCPC] = 1'b1; v[B_ZLIN] = 1'b1;
         end
         P_T1: begin
            v[B_RUN] = 1'b1; v[B_ZLOUT] = 1'b1; v[B_PCEN] = 1'b1;
            v[B_MDRRD] = 1'b1; v[B_MDREN] = 1'b1;
         end
         P_T1W: begin
            v[B_RUN] = 1'b1; v[B_MDRRD] = 1'b1; v[B_MDREN] = 1'b1;
         end
         P_T2: begin
            v[B_RUN] = 1'b1; v[B_MDROUT] = 1'b1; v[B_IREN] = 1'b1;
         end
         P_T3: begin
            v[B_RUN] = 1'b1;
            case (opc)
               5'b11000: begin v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; v[B_HI] = 1'b1; end
               5'b11001: begin v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; v[B_LO] = 1'b1; end
               5'b10110: begin v[B_GRA] = 1'b1; v[B_RIN] = 1'b1; v[B_INP] = 1'b1; end
               5'b10111: begin v[B_GRA] = 1'b1; v[B_ROUT] = 1'b1; v[B_OUTEN] = 1'b1; end
               5'b10100: begin v[B_GRA] = 1'b1; v[B_ROUT] = 1'b1; v[B_PCEN] = 1'b1; end
               5'b11010, 5'b11011: v = v;
               default: v[B_ILL] = 1'b1;
            endcase
         end
         default: v = 19'd0;
      endcase
      return v;
   endfunction

   task automatic check_val(input string tag, input logic [18:0] act, input logic [18:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp_v);
      end
   endtask

   function logic [18:0] dut_vec(input int w);
      return (w == 0) ? vec_a : vec_b;
   endfunction

   task automatic push_instr(input int mw, input logic [31:0] ir);
      exp_q.push_back(exp_vec(P_T0, 5'd0));
      exp_q.push_back(exp_vec(P_T1, 5'd0));
      for (int i = 0; i < mw; i++) exp_q.push_back(exp_vec(P_T1W, 5'd0));
      exp_q.push_back(exp_vec(P_T2, 5'd0));
      exp_q.push_back(exp_vec(P_T3, ir[31:27]));
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(19'd0);
   endtask

   task automatic drain_n(input int w, input string tag, input int n);
      for (int i = 0; i < n && exp_q.size() > 0; i++) begin
         @(negedge clk);
         check_val(tag, dut_vec(w), exp_q.pop_front());
      end
   endtask

   task automatic drain(input int w, input string tag);
      drain_n(w, tag, exp_q.size());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ops [4];
      ops = '{32'hC0000000, 32'hB0000000, 32'hB8000000, 32'hD0000000};
      clr_a = 1'b1; clr_b = 1'b1; stop_a = 1'b0; stop_b = 1'b0;
      ir_a = 32'hC8800000; ir_b = 32'hB9800000;
      repeat (2) @(negedge clk);
      check_val("reset_w0", vec_a, 19'd0);
      check_val("reset_w2", vec_b, 19'd0);

      // MEM_WAIT = 0 unit: mflo, jr, then a mix of other opcodes
      clr_a = 1'b0;
      push_instr(0, ir_a);
      drain(0, "mflo");
      ir_a = 32'hA2800000;
      push_instr(0, ir_a);
      drain(0, "jr");
      foreach (ops[k]) begin
         ir_a = ops[k];
         push_instr(0, ir_a);
         drain(0, "mix");
      end

      // Stop raised in T1 of a nop; instruction finishes, then STOPPED
      ir_a = 32'hD0000000;
      push_instr(0, ir_a);
      drain_n(0, "nop_stop", 2);
      stop_a = 1'b1;
      drain(0, "nop_stop");
      push_idle(3);
      drain(0, "stopped");
      stop_a = 1'b0;

      // halt, then 20 idle cycles, then Clear pulse restarts fetch
      ir_a = 32'hD8000000;
      push_instr(0, ir_a);
      drain(0, "halt");
      push_idle(20);
      drain(0, "halted");
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      ir_a = 32'hC0000000;
      push_instr(0, ir_a);
      drain(0, "after_halt_clear");
      clr_a = 1'b1;

      // MEM_WAIT = 2 unit: out, illegal opcode, then Clear inside T1W
      clr_b = 1'b0;
      push_instr(2, ir_b);
      drain(1, "out_w2");
      ir_b = 32'h00000000;
      push_instr(2, ir_b);
      drain(1, "illegal");
      ir_b = 32'hC8800000;
      push_instr(2, ir_b);
      drain_n(1, "pre_abort", 3);
      exp_q.delete();
      #2 clr_b = 1'b1;
      #1 check_val("clear_async", vec_b, 19'd0);
      @(negedge clk);
      clr_b = 1'b0;
      ir_b = 32'hB0000000;
      push_instr(2, ir_b);
      drain(1, "post_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Hardwired control sequencer for the multi-cycle datapath.
- Drives the same control strobes that benches currently hand-sequence for fetch and for the register-move/IO class: mfhi, mflo, in, out, jr, nop, halt.
- Sits beside the datapath: it reads IR and produces one-hot, per-cycle control strobes, so benches only load memory and release Clear.

Parameters:
- MEM_WAIT, 0: extra cycles T1 holds MDR_read/MDR_enable before T2 (range 0-7).
- OPC_MSB, 31: top bit of the 5-bit opcode field in IR.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Clear  in  1  reset; asynchronous, active-high.
- IR  in  32  instruction register contents; opcode = IR[31:27].
- Stop  in  1  pause request, sampled only at instruction boundary.
- Run  out  1  high while sequencing; low in reset, STOPPED or HALTED.
- Illegal  out  1  one-cycle pulse in T3 for an unsupported opcode.
- PCout, MAR_enable, IncPC, ZLowIn, ZLowout, PC_enable, MDR_read, MDR_enable, MDRout, IR_enable  out  1 each  fetch strobes.
- Gra, R_in, R_out, HIout, LOout, InPortout, OutPort_enable  out  1 each  execute strobes.

Behaviour:
- State register updates on posedge Clock. Clear high forces state RESET immediately, asynchronously.
- Strobes and Illegal are a pure decode of state, IR opcode and the wait counter. Run is high in every state except RESET, STOPPED and HALTED.
- Reset values: all strobes 0, Run 0, Illegal 0, wait counter 0.
- States: RESET, T0, T1, T1W, T2, T3, STOPPED, HALTED.
- RESET -> T0 on the first edge after Clear deasserts.
- T0: PCout, MAR_enable, IncPC, ZLowIn = 1.
- T1: ZLowout, PC_enable, MDR_read, MDR_enable = 1.
  - MEM_WAIT = 0: go to T2.
  - MEM_WAIT > 0: load counter with MEM_WAIT-1, go to T1W.
- T1W: only MDR_read and MDR_enable = 1. Counter decrements each cycle; at 0 go to T2.
- T2: MDRout, IR_enable = 1. IR is valid from T3 onward; IR is not sampled earlier.
- T3 execute, by opcode IR[31:27]:
  - mfhi 11000: Gra, R_in, HIout.
  - mflo 11001: Gra, R_in, LOout.
  - in 10110: Gra, R_in, InPortout.
  - out 10111: Gra, R_out, OutPort_enable.
  - jr 10100: Gra, R_out, PC_enable.
  - nop 11010: no strobes.
  - halt 11011: no strobes; next state HALTED.
  - any other opcode: no strobes, Illegal = 1, treated as nop.
- T3 exit (non-halt): Stop = 1 -> STOPPED; otherwise -> T0.
- STOPPED: no strobes. Returns to T0 on the first edge with Stop = 0.
- HALTED: no strobes. Left only via Clear.
- Instruction latency: 4 + MEM_WAIT cycles, T0 to T3 inclusive.
- Stop asserted at any time other than T3 is ignored until the next T3; an in-flight instruction always completes.
- Clear mid-instruction (including T1W or T3) aborts immediately: all strobes drop in the same cycle and the counter clears.
- Opcode changes outside T3 have no effect on the strobes.
- Invariants:
  - At most one register-file read/write enable (R_in, R_out) per cycle.
  - Never more than one bus driver (PCout, ZLowout, MDRout, HIout, LOout, InPortout, R_out) per cycle.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the state enum with a 4-bit encoding;
  - opcode localparams OP_MFHI, OP_MFLO, OP_IN, OP_OUT, OP_JR, OP_NOP, OP_HALT;
  - the opcode field slice constants.
- One sub-module: ctrl_opcode_decode. It is combinational, maps IR[31:27] to a one-hot execute class plus an illegal flag, and is reused when ALU opcodes are added.

Test Plan:
- Release Clear at cycle 0, IR = 0xC8800000 (mflo r1) -> T0 at cycle 1 with PCout, MAR_enable, IncPC, ZLowIn; in T3 exactly Gra, R_in, LOout = 1; back in T0 at cycle 5.
- IR = 0xB9800000 (out r3), MEM_WAIT = 2 -> T1W lasts 2 cycles with only MDR_read/MDR_enable; T3 asserts Gra, R_out, OutPort_enable at cycle 6.
- IR = 0xA2800000 (jr r5) -> T3 asserts Gra, R_out, PC_enable; Illegal stays 0.
- IR = 0xD8000000 (halt) -> after T3, Run = 0 and all strobes 0 for 20 cycles; Clear pulse returns the unit to T0.
- Stop = 1 raised in T1 with nop 0xD0000000 -> instruction completes through T3, then STOPPED with Run = 0; Stop = 0 -> T0 on the next edge.
- IR = 0x00000000 -> Illegal pulses for exactly the T3 cycle. Then assert Clear mid-T1W -> strobes drop the same cycle without waiting for a clock edge.
